// File: rtl/core_uop_pkg.sv
// Shared uop field layout and thread identifiers for the two-thread 65HE06 core.
package core_uop_pkg;

    // Uop field positions
    localparam int UOP_STORE_BIT = 13;
    localparam int UOP_DEST_HI   = 11;
    localparam int UOP_DEST_LO   = 8;
    localparam int UOP_SRC0_HI   = 2;
    localparam int UOP_SRC0_LO   = 0;
    localparam int UOP_SRC1_HI   = 5;
    localparam int UOP_SRC1_LO   = 3;

    // Hardware thread identifiers
    localparam logic THREAD_A = 1'b0;
    localparam logic THREAD_B = 1'b1;

endpackage

// File: rtl/uop_fifo.sv
// Per-thread uop FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart by the MSB compare. Flush takes priority over push and pop.
// DEPTH must be a power of two, at least 2.
module uop_fifo #(
    parameter int W     = 21,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer update: flush rewinds both pointers, discarding all entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate reads
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dual_thread_issue.sv
// Dual-thread issue stage: buffers uops per thread and picks one per cycle
// for execute, filling memory-stall slots with hazard-free uops from the
// non-main thread.
//
// Handshake: an input uop transfers when x_valid & x_ready on a rising edge.
// The issue register transfers to execute when issue_valid & ex_ready; while
// issue_valid is high and ex_ready is low, issue_* hold stable.
module dual_thread_issue
    import core_uop_pkg::*;
#(
    parameter int UOP_W     = 20,
    parameter int DEPTH     = 4,
    parameter int MAX_STEAL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [UOP_W-1:0] a_uop,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [UOP_W-1:0] b_uop,
    input  logic             b_last,
    output logic             b_ready,
    input  logic             flush_a,
    input  logic             flush_b,
    input  logic             ex_ready,
    input  logic             ex_doing_mem,
    output logic             issue_valid,
    output logic [UOP_W-1:0] issue_uop,
    output logic             issue_thread,
    output logic             issue_last,
    output logic             main_thread
);
    localparam int SCW = $clog2(MAX_STEAL + 1);

    // FIFO entries are {last, uop}
    logic [UOP_W:0]   head_a, head_b;
    logic             full_a, full_b, empty_a, empty_b;
    logic             pop_a, pop_b;

    logic [UOP_W-1:0] last_a, last_b;
    logic             lv_a, lv_b;
    logic [SCW-1:0]   steal_cnt;

    // Selection view, rotated so M is the main thread and O the other
    logic [UOP_W:0]   head_m, head_o, sel_head;
    logic             empty_m, empty_o;
    logic [UOP_W-1:0] last_m;
    logic             lv_m;
    logic [3:0]       dest_m;
    logic             hazard, alt_ok, steal, advance;
    logic             pop_m, pop_o, sel_thread;

    assign a_ready = ~full_a;
    assign b_ready = ~full_b;

    uop_fifo #(.W(UOP_W + 1), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (a_valid),
        .pop   (pop_a),
        .flush (flush_a),
        .din   ({a_last, a_uop}),
        .full  (full_a),
        .empty (empty_a),
        .head  (head_a)
    );

    uop_fifo #(.W(UOP_W + 1), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (b_valid),
        .pop   (pop_b),
        .flush (flush_b),
        .din   ({b_last, b_uop}),
        .full  (full_b),
        .empty (empty_b),
        .head  (head_b)
    );

    // Issue selection: a thread being flushed this cycle is treated as empty
    always_comb begin
        head_m  = head_a;
        head_o  = head_b;
        empty_m = empty_a | flush_a;
        empty_o = empty_b | flush_b;
        last_m  = last_a;
        lv_m    = lv_a;
        if (main_thread == THREAD_B) begin
            head_m  = head_b;
            head_o  = head_a;
            empty_m = empty_b | flush_b;
            empty_o = empty_a | flush_a;
            last_m  = last_b;
            lv_m    = lv_b;
        end
        dest_m  = last_m[UOP_DEST_HI:UOP_DEST_LO];
        hazard  = lv_m & (last_m[UOP_STORE_BIT]
                          | ({1'b0, head_o[UOP_SRC0_HI:UOP_SRC0_LO]} == dest_m)
                          | ({1'b0, head_o[UOP_SRC1_HI:UOP_SRC1_LO]} == dest_m));
        alt_ok  = ~empty_o & ~head_o[UOP_STORE_BIT] & ~head_o[UOP_W] & ~hazard;
        steal   = alt_ok & (empty_m | (ex_doing_mem & (steal_cnt < SCW'(MAX_STEAL))));
        advance = ~issue_valid | ex_ready;
        pop_o   = advance & steal;
        pop_m   = advance & ~steal & ~empty_m;
        pop_a   = (main_thread == THREAD_A) ? pop_m : pop_o;
        pop_b   = (main_thread == THREAD_A) ? pop_o : pop_m;
        sel_head   = steal ? head_o : head_m;
        sel_thread = steal ? ~main_thread : main_thread;
    end

    // Issue register: load on advance, otherwise hold; flush kills a held uop of that thread
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid  <= 1'b0;
            issue_uop    <= '0;
            issue_thread <= THREAD_A;
            issue_last   <= 1'b0;
        end else if (advance) begin
            if (pop_m | pop_o) begin
                issue_valid  <= 1'b1;
                issue_uop    <= sel_head[UOP_W-1:0];
                issue_thread <= sel_thread;
                issue_last   <= sel_head[UOP_W];
            end else begin
                issue_valid  <= 1'b0;
            end
        end else if (issue_valid && ((flush_a && issue_thread == THREAD_A) ||
                                     (flush_b && issue_thread == THREAD_B))) begin
            issue_valid <= 1'b0;
        end
    end

    // Main thread ownership passes on when main issues the last uop of an instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_thread <= THREAD_A;
        end else if (pop_m && head_m[UOP_W]) begin
            main_thread <= ~main_thread;
        end
    end

    // Steal counter: counts steals taken while main had work, cleared when main issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steal_cnt <= '0;
        end else if ((flush_a && flush_b) || pop_m) begin
            steal_cnt <= '0;
        end else if (pop_o && !empty_m && (steal_cnt < SCW'(MAX_STEAL))) begin
            steal_cnt <= steal_cnt + 1'b1;
        end
    end

    // Last-issued uop per thread, the reference for cross-thread hazard checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a <= '0;
            lv_a   <= 1'b0;
            last_b <= '0;
            lv_b   <= 1'b0;
        end else begin
            if (flush_a) begin
                last_a <= '0;
                lv_a   <= 1'b0;
            end else if (pop_a) begin
                last_a <= head_a[UOP_W-1:0];
                lv_a   <= 1'b1;
            end
            if (flush_b) begin
                last_b <= '0;
                lv_b   <= 1'b0;
            end else if (pop_b) begin
                last_b <= head_b[UOP_W-1:0];
                lv_b   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_thread_issue.sv
// Directed bench for dual_thread_issue: inputs change 1 time unit after the
// rising edge, outputs are checked at that same point, well away from the edge.
module tb_dual_thread_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, a_last, a_ready;
    logic [19:0] a_uop;
    logic        b_valid, b_last, b_ready;
    logic [19:0] b_uop;
    logic        flush_a, flush_b, ex_ready, ex_doing_mem;
    logic        issue_valid, issue_thread, issue_last, main_thread;
    logic [19:0] issue_uop;

    int n_checks = 0;
    int n_errors = 0;

    dual_thread_issue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_uop        (a_uop),
        .a_last       (a_last),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_uop        (b_uop),
        .b_last       (b_last),
        .b_ready      (b_ready),
        .flush_a      (flush_a),
        .flush_b      (flush_b),
        .ex_ready     (ex_ready),
        .ex_doing_mem (ex_doing_mem),
        .issue_valid  (issue_valid),
        .issue_uop    (issue_uop),
        .issue_thread (issue_thread),
        .issue_last   (issue_last),
        .main_thread  (main_thread)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_uop = '0; a_last = 0;
        b_valid = 0; b_uop = '0; b_last = 0;
        flush_a = 0; flush_b = 0; ex_ready = 0; ex_doing_mem = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL reset_a_ready: got %b exp 1", a_ready); end
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL reset_b_ready: got %b exp 1", b_ready); end
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL reset_issue_valid: got %b exp 0", issue_valid); end
        n_checks++; if (issue_uop !== 20'h0) begin n_errors++; $display("FAIL reset_issue_uop: got %h exp 00000", issue_uop); end
        n_checks++; if (issue_thread !== 1'b0 || issue_last !== 1'b0) begin n_errors++; $display("FAIL reset_thread_last: got %b%b exp 00", issue_thread, issue_last); end
        n_checks++; if (main_thread !== 1'b0) begin n_errors++; $display("FAIL reset_main: got %b exp 0", main_thread); end
    endtask

    task automatic test_basic_issue();
        do_reset();
        ex_ready = 1;
        a_valid = 1; a_uop = 20'h00123; a_last = 0;
        tick();
        a_uop = 20'h00234; a_last = 1;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_uop !== 20'h00123) begin n_errors++; $display("FAIL basic_first: got v=%b %h exp v=1 00123", issue_valid, issue_uop); end
        n_checks++; if (issue_thread !== 1'b0 || issue_last !== 1'b0) begin n_errors++; $display("FAIL basic_first_tl: got %b%b exp 00", issue_thread, issue_last); end
        n_checks++; if (main_thread !== 1'b0) begin n_errors++; $display("FAIL basic_main0: got %b exp 0", main_thread); end
        a_valid = 0; a_last = 0;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_uop !== 20'h00234 || issue_last !== 1'b1) begin n_errors++; $display("FAIL basic_second: got v=%b %h l=%b exp v=1 00234 l=1", issue_valid, issue_uop, issue_last); end
        n_checks++; if (issue_thread !== 1'b0) begin n_errors++; $display("FAIL basic_second_thread: got %b exp 0", issue_thread); end
        n_checks++; if (main_thread !== 1'b1) begin n_errors++; $display("FAIL basic_handoff: got %b exp 1", main_thread); end
        tick();
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %b exp 0", issue_valid); end
        // Flushing the main thread leaves ownership where it is
        flush_b = 1;
        tick();
        flush_b = 0;
        n_checks++; if (main_thread !== 1'b1) begin n_errors++; $display("FAIL flush_main_stays: got %b exp 1", main_thread); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        a_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_uop = 20'h00040 + 20'(i);
            tick();
        end
        a_valid = 0;
        rst_n = 0;
        #2;
        n_checks++; if (issue_valid !== 1'b0 || a_ready !== 1'b1) begin n_errors++; $display("FAIL midop_reset: got v=%b rdy=%b exp v=0 rdy=1", issue_valid, a_ready); end
        @(posedge clk);
        #1 rst_n = 1;
        ex_ready = 1;
        tick();
        tick();
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL midop_dropped: got %b exp 0", issue_valid); end
    endtask

    task automatic test_steal_hazard();
        do_reset();
        ex_ready = 1;
        a_valid = 1; a_uop = 20'h00200;
        tick();
        a_valid = 0;
        tick();
        n_checks++; if (issue_uop !== 20'h00200 || issue_thread !== 1'b0) begin n_errors++; $display("FAIL steal_setup: got %h t=%b exp 00200 t=0", issue_uop, issue_thread); end
        // last_A dest=2, B sources are 1: no hazard, B steals the memory slot
        ex_doing_mem = 1;
        a_valid = 1; a_uop = 20'h00100;
        b_valid = 1; b_uop = 20'h00009;
        tick();
        a_valid = 0; b_valid = 0;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_thread !== 1'b1 || issue_uop !== 20'h00009) begin n_errors++; $display("FAIL steal_taken: got v=%b t=%b %h exp v=1 t=1 00009", issue_valid, issue_thread, issue_uop); end
        tick();
        n_checks++; if (issue_thread !== 1'b0 || issue_uop !== 20'h00100) begin n_errors++; $display("FAIL steal_then_main: got t=%b %h exp t=0 00100", issue_thread, issue_uop); end
        // last_A dest=1 matches B src0: hazard, A issues first
        a_valid = 1; a_uop = 20'h00400;
        b_valid = 1; b_uop = 20'h00009;
        tick();
        a_valid = 0; b_valid = 0;
        tick();
        n_checks++; if (issue_thread !== 1'b0 || issue_uop !== 20'h00400) begin n_errors++; $display("FAIL hazard_blocks: got t=%b %h exp t=0 00400", issue_thread, issue_uop); end
        tick();
        n_checks++; if (issue_thread !== 1'b1 || issue_uop !== 20'h00009) begin n_errors++; $display("FAIL hazard_cleared: got t=%b %h exp t=1 00009", issue_thread, issue_uop); end
    endtask

    task automatic test_store_no_steal();
        do_reset();
        ex_ready = 1; ex_doing_mem = 1;
        a_valid = 1; a_uop = 20'h00100;
        b_valid = 1; b_uop = 20'h02000;
        tick();
        a_valid = 0; b_valid = 0;
        tick();
        n_checks++; if (issue_thread !== 1'b0 || issue_uop !== 20'h00100) begin n_errors++; $display("FAIL store_main_first: got t=%b %h exp t=0 00100", issue_thread, issue_uop); end
        tick();
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL store_never_steals: got %b exp 0", issue_valid); end
        tick();
        n_checks++; if (issue_valid !== 1'b0 || b_ready !== 1'b1) begin n_errors++; $display("FAIL store_held: got v=%b rdy=%b exp v=0 rdy=1", issue_valid, b_ready); end
    endtask

    task automatic test_stall_full();
        logic [19:0] exp_uop;
        do_reset();
        a_valid = 1; a_uop = 20'h00011;
        tick();
        a_valid = 0;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_uop !== 20'h00011) begin n_errors++; $display("FAIL stall_load: got v=%b %h exp v=1 00011", issue_valid, issue_uop); end
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_uop = 20'h00021 + 20'(i);
            tick();
            n_checks++; if (issue_valid !== 1'b1 || issue_uop !== 20'h00011) begin n_errors++; $display("FAIL stall_hold_%0d: got v=%b %h exp v=1 00011", i, issue_valid, issue_uop); end
            n_checks++; if (a_ready !== (i < 3)) begin n_errors++; $display("FAIL stall_ready_%0d: got %b exp %b", i, a_ready, (i < 3)); end
        end
        // Full with a pop in the same cycle: the offered uop must not slip in
        a_uop = 20'h00025; ex_ready = 1;
        tick();
        a_valid = 0;
        for (int i = 0; i < 4; i++) begin
            exp_uop = 20'h00021 + 20'(i);
            n_checks++; if (issue_valid !== 1'b1 || issue_uop !== exp_uop) begin n_errors++; $display("FAIL drain_%0d: got v=%b %h exp v=1 %h", i, issue_valid, issue_uop, exp_uop); end
            tick();
        end
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL no_bypass: got v=%b %h exp v=0", issue_valid, issue_uop); end
    endtask

    task automatic test_steal_limit();
        logic        exp_t [9];
        logic [19:0] exp_u [9];
        exp_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_u = '{20'h10000, 20'h10001, 20'h10002, 20'h00F00, 20'h10003,
                  20'h10004, 20'h00F01, 20'h00F02, 20'h00F03};
        do_reset();
        ex_doing_mem = 1;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_uop = 20'h00F00 + 20'(i);
            b_valid = 1; b_uop = 20'h10000 + 20'(i);
            tick();
        end
        a_valid = 0;
        b_uop = 20'h10004;
        tick();
        b_valid = 0;
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_errors++; $display("FAIL limit_full: got a=%b b=%b exp 0 0", a_ready, b_ready); end
        ex_ready = 1;
        for (int i = 0; i < 9; i++) begin
            n_checks++; if (issue_valid !== 1'b1 || issue_thread !== exp_t[i] || issue_uop !== exp_u[i]) begin n_errors++; $display("FAIL limit_seq_%0d: got v=%b t=%b %h exp v=1 t=%b %h", i, issue_valid, issue_thread, issue_uop, exp_t[i], exp_u[i]); end
            tick();
        end
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL limit_end: got %b exp 0", issue_valid); end
    endtask

    task automatic test_flush_b();
        do_reset();
        b_valid = 1;
        for (int i = 0; i < 4; i++) begin
            b_uop = 20'h00010 + 20'(i);
            tick();
        end
        n_checks++; if (issue_valid !== 1'b1 || issue_thread !== 1'b1 || issue_uop !== 20'h00010) begin n_errors++; $display("FAIL flush_setup: got v=%b t=%b %h exp v=1 t=1 00010", issue_valid, issue_thread, issue_uop); end
        flush_b = 1; b_uop = 20'h00099;
        tick();
        flush_b = 0; b_valid = 0;
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL flush_kills_issue: got %b exp 0", issue_valid); end
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL flush_b_ready: got %b exp 1", b_ready); end
        ex_ready = 1;
        tick();
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL flush_push_dropped: got v=%b %h exp v=0", issue_valid, issue_uop); end
        tick();
        n_checks++; if (issue_valid !== 1'b0) begin n_errors++; $display("FAIL flush_empty: got v=%b %h exp v=0", issue_valid, issue_uop); end
        b_valid = 1; b_uop = 20'h00055;
        tick();
        b_valid = 0;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_thread !== 1'b1 || issue_uop !== 20'h00055) begin n_errors++; $display("FAIL flush_reuse: got v=%b t=%b %h exp v=1 t=1 00055", issue_valid, issue_thread, issue_uop); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_basic_issue();
        test_reset_midop();
        test_steal_hazard();
        test_store_no_steal();
        test_stall_full();
        test_steal_limit();
        test_flush_b();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
